// File: rtl/cpu_types_pkg.sv
// Shared pipeline-control types: sequencer states, per-latch control pair and
// register-select width.
package cpu_types_pkg;

    typedef logic [4:0] regbits_t;

    typedef enum logic [1:0] {
        RUN,
        DWAIT,
        DRAIN,
        HALTED
    } pipe_state_t;

    typedef struct packed {
        logic en;
        logic flush;
    } latch_ctrl_t;

    // A flushed latch must never also capture its input.
    function automatic latch_ctrl_t resolve_latch(input latch_ctrl_t c);
        latch_ctrl_t r;
        r.flush = c.flush;
        r.en    = c.en & ~c.flush;
        return r;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EX whose destination feeds an ID source operand.
module hazard_detect
    import cpu_types_pkg::*;
(
    input  logic     idex_memread,
    input  regbits_t idex_wsel,
    input  regbits_t ifid_rs,
    input  regbits_t ifid_rt,
    output logic     lu
);

    // Register 0 is hardwired, so a load targeting it never creates a hazard.
    always_comb begin
        lu = idex_memread && (idex_wsel != '0) &&
             ((idex_wsel == ifid_rs) || (idex_wsel == ifid_rt));
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline sequencer: per-latch enable/flush, PC enable, halt drain sequencing,
// stall counter and data-cache wait watchdog.
module pipe_ctrl_unit
    import cpu_types_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned DWAIT_MAX    = 255,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             exmem_memread,
    input  logic             exmem_memwrite,
    input  logic             exmem_xfer,
    input  logic             exmem_halt,
    input  logic             idex_memread,
    input  regbits_t         idex_wsel,
    input  regbits_t         ifid_rs,
    input  regbits_t         ifid_rt,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             exmem_flush,
    output logic             memwb_en,
    output logic             memwb_flush,
    output logic             halt,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned DC_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int unsigned DW_W = (DWAIT_MAX > 1) ? $clog2(DWAIT_MAX + 1) : 1;
    localparam logic [DC_W-1:0] DRAIN_LOAD = DC_W'(DRAIN_CYCLES - 1);
    localparam logic [DW_W-1:0] DWAIT_LIM  = DW_W'(DWAIT_MAX);

    pipe_state_t     state, next_state;
    logic [DC_W-1:0] drain_cnt;
    logic [DW_W-1:0] dwait_cnt;
    logic            lu;
    logic            memop;
    logic            pc_go;
    latch_ctrl_t     ifid_c, idex_c, exmem_c, memwb_c;
    latch_ctrl_t     ifid_r, idex_r, exmem_r, memwb_r;

    hazard_detect u_hazard (
        .idex_memread (idex_memread),
        .idex_wsel    (idex_wsel),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .lu           (lu)
    );

    assign memop = exmem_memread | exmem_memwrite;

    always_comb begin
        next_state = state;
        pc_go      = 1'b0;
        ifid_c     = '0;
        idex_c     = '0;
        exmem_c    = '0;
        memwb_c    = '0;
        case (state)
            RUN, DWAIT: begin
                if (memop && !dhit) begin
                    next_state = DWAIT;
                end else begin
                    next_state = RUN;
                    if (exmem_xfer) begin
                        pc_go         = 1'b1;
                        ifid_c.flush  = 1'b1;
                        idex_c.flush  = 1'b1;
                        exmem_c.flush = 1'b1;
                        memwb_c.en    = 1'b1;
                    end else if (lu) begin
                        idex_c.flush  = 1'b1;
                        exmem_c.en    = 1'b1;
                        memwb_c.en    = 1'b1;
                    end else if (!ihit) begin
                        ifid_c.flush  = 1'b1;
                        idex_c.en     = 1'b1;
                        exmem_c.en    = 1'b1;
                        memwb_c.en    = 1'b1;
                    end else begin
                        pc_go         = 1'b1;
                        ifid_c.en     = 1'b1;
                        idex_c.en     = 1'b1;
                        exmem_c.en    = 1'b1;
                        memwb_c.en    = 1'b1;
                    end
                    // Every non-freeze rule advances MEM/WB, so the halt leaves EX/MEM here.
                    if (exmem_halt) begin
                        next_state = DRAIN;
                    end
                end
            end
            DRAIN: begin
                ifid_c.flush  = 1'b1;
                idex_c.flush  = 1'b1;
                exmem_c.flush = 1'b1;
                memwb_c.en    = 1'b1;
                if (drain_cnt == '0) begin
                    next_state = HALTED;
                end
            end
            HALTED: begin
                next_state = HALTED;
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    assign ifid_r  = resolve_latch(ifid_c);
    assign idex_r  = resolve_latch(idex_c);
    assign exmem_r = resolve_latch(exmem_c);
    assign memwb_r = resolve_latch(memwb_c);

    // Gating with nRST keeps every control low while reset is asserted.
    assign pc_en       = nRST & pc_go;
    assign ifid_en     = nRST & ifid_r.en;
    assign ifid_flush  = nRST & ifid_r.flush;
    assign idex_en     = nRST & idex_r.en;
    assign idex_flush  = nRST & idex_r.flush;
    assign exmem_en    = nRST & exmem_r.en;
    assign exmem_flush = nRST & exmem_r.flush;
    assign memwb_en    = nRST & memwb_r.en;
    assign memwb_flush = nRST & memwb_r.flush;
    assign halt        = (state == HALTED);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= RUN;
            drain_cnt   <= '0;
            dwait_cnt   <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
        end else begin
            state <= next_state;

            if (state != DRAIN && next_state == DRAIN) begin
                drain_cnt <= DRAIN_LOAD;
            end else if (state == DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DC_W'(1);
            end

            if (next_state == RUN) begin
                dwait_cnt <= '0;
            end else if (state == DWAIT && dwait_cnt != '1) begin
                dwait_cnt <= dwait_cnt + DW_W'(1);
                if (dwait_cnt + DW_W'(1) >= DWAIT_LIM) begin
                    mem_timeout <= 1'b1;
                end
            end

            if ((state == RUN || state == DWAIT) && !pc_go && stall_count != '1) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit with DRAIN_CYCLES=2 and DWAIT_MAX=4.
module tb_pipe_ctrl_unit;

    // Control vector order: pc, ifid en/flush, idex en/flush, exmem en/flush, memwb en/flush.
    localparam logic [8:0] C_ALL    = 9'b1_10_10_10_10;
    localparam logic [8:0] C_FREEZE = 9'b0_00_00_00_00;
    localparam logic [8:0] C_XFER   = 9'b1_01_01_01_10;
    localparam logic [8:0] C_LU     = 9'b0_00_01_10_10;
    localparam logic [8:0] C_IMISS  = 9'b0_01_10_10_10;
    localparam logic [8:0] C_DRAIN  = 9'b0_01_01_01_10;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit;
    logic        exmem_memread, exmem_memwrite, exmem_xfer, exmem_halt;
    logic        idex_memread;
    logic [4:0]  idex_wsel, ifid_rs, ifid_rt;
    logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic        exmem_en, exmem_flush, memwb_en, memwb_flush;
    logic        halt, mem_timeout;
    logic [31:0] stall_count;
    logic [8:0]  ctl;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                  exmem_en, exmem_flush, memwb_en, memwb_flush};

    pipe_ctrl_unit #(
        .DRAIN_CYCLES (2),
        .DWAIT_MAX    (4),
        .CNT_W        (32)
    ) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .ihit           (ihit),
        .dhit           (dhit),
        .exmem_memread  (exmem_memread),
        .exmem_memwrite (exmem_memwrite),
        .exmem_xfer     (exmem_xfer),
        .exmem_halt     (exmem_halt),
        .idex_memread   (idex_memread),
        .idex_wsel      (idex_wsel),
        .ifid_rs        (ifid_rs),
        .ifid_rt        (ifid_rt),
        .pc_en          (pc_en),
        .ifid_en        (ifid_en),
        .ifid_flush     (ifid_flush),
        .idex_en        (idex_en),
        .idex_flush     (idex_flush),
        .exmem_en       (exmem_en),
        .exmem_flush    (exmem_flush),
        .memwb_en       (memwb_en),
        .memwb_flush    (memwb_flush),
        .halt           (halt),
        .mem_timeout    (mem_timeout),
        .stall_count    (stall_count)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0;
        exmem_memread = 1'b0; exmem_memwrite = 1'b0;
        exmem_xfer = 1'b0; exmem_halt = 1'b0;
        idex_memread = 1'b0; idex_wsel = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        idle_inputs();
        ihit = 1'b0;
        tick();
        tests++; if (ctl !== C_FREEZE) begin fails++; $display("FAIL reset_ctl got %b want %b", ctl, C_FREEZE); end
        tests++; if (halt !== 1'b0) begin fails++; $display("FAIL reset_halt got %b want 0", halt); end
        tests++; if (stall_count !== 32'd0) begin fails++; $display("FAIL reset_stall got %0d want 0", stall_count); end
        tests++; if (mem_timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b want 0", mem_timeout); end
        nRST = 1'b1; ihit = 1'b1;
        #1;
        tests++; if (ctl !== C_ALL) begin fails++; $display("FAIL reset_release_ctl got %b want %b", ctl, C_ALL); end
        tick();
    endtask

    task automatic test_dcache_wait();
        idle_inputs();
        exmem_memread = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (ctl !== C_FREEZE) begin fails++; $display("FAIL dwait_freeze[%0d] got %b want %b", i, ctl, C_FREEZE); end
            tick();
        end
        dhit = 1'b1;
        #1;
        tests++; if (ctl !== C_ALL) begin fails++; $display("FAIL dwait_dhit got %b want %b", ctl, C_ALL); end
        tick();
        idle_inputs();
        tests++; if (stall_count !== 32'd3) begin fails++; $display("FAIL dwait_stall got %0d want 3", stall_count); end
    endtask

    task automatic test_load_use();
        idle_inputs();
        idex_memread = 1'b1; idex_wsel = 5'd8; ifid_rt = 5'd8; ifid_rs = 5'd1;
        #1;
        tests++; if (ctl !== C_LU) begin fails++; $display("FAIL lu_rt got %b want %b", ctl, C_LU); end
        tick();
        idex_wsel = 5'd0; ifid_rt = 5'd0; ifid_rs = 5'd0;
        #1;
        tests++; if (ctl !== C_ALL) begin fails++; $display("FAIL lu_r0 got %b want %b", ctl, C_ALL); end
        tick();
        idex_wsel = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd9;
        #1;
        tests++; if (ctl !== C_LU) begin fails++; $display("FAIL lu_rs got %b want %b", ctl, C_LU); end
        tick();
        idle_inputs();
        tests++; if (stall_count !== 32'd5) begin fails++; $display("FAIL lu_stall got %0d want 5", stall_count); end
    endtask

    task automatic test_xfer();
        idle_inputs();
        exmem_xfer = 1'b1; ihit = 1'b0;
        idex_memread = 1'b1; idex_wsel = 5'd3; ifid_rs = 5'd3;
        #1;
        tests++; if (ctl !== C_XFER) begin fails++; $display("FAIL xfer_wins got %b want %b", ctl, C_XFER); end
        tick();
        idle_inputs(); ihit = 1'b0;
        #1;
        tests++; if (ctl !== C_IMISS) begin fails++; $display("FAIL imiss got %b want %b", ctl, C_IMISS); end
        tick();
        idle_inputs();
        exmem_xfer = 1'b1; exmem_memread = 1'b1;
        #1;
        tests++; if (ctl !== C_FREEZE) begin fails++; $display("FAIL xfer_freeze got %b want %b", ctl, C_FREEZE); end
        tick();
        dhit = 1'b1;
        #1;
        tests++; if (ctl !== C_XFER) begin fails++; $display("FAIL xfer_after_dwait got %b want %b", ctl, C_XFER); end
        tick();
        idle_inputs();
        tests++; if (stall_count !== 32'd7) begin fails++; $display("FAIL xfer_stall got %0d want 7", stall_count); end
    endtask

    task automatic test_watchdog();
        idle_inputs();
        tests++; if (mem_timeout !== 1'b0) begin fails++; $display("FAIL wd_initial got %b want 0", mem_timeout); end
        exmem_memwrite = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            #1;
            tests++; if (ctl !== C_FREEZE) begin fails++; $display("FAIL wd_freeze[%0d] got %b want %b", i, ctl, C_FREEZE); end
            tick();
            if (i == 4) begin
                tests++; if (mem_timeout !== 1'b0) begin fails++; $display("FAIL wd_early got %b want 0", mem_timeout); end
            end
        end
        tests++; if (mem_timeout !== 1'b1) begin fails++; $display("FAIL wd_set got %b want 1", mem_timeout); end
        dhit = 1'b1;
        #1;
        tests++; if (ctl !== C_ALL) begin fails++; $display("FAIL wd_release got %b want %b", ctl, C_ALL); end
        tick();
        idle_inputs();
        tick();
        tick();
        tests++; if (mem_timeout !== 1'b1) begin fails++; $display("FAIL wd_sticky got %b want 1", mem_timeout); end
        tests++; if (stall_count !== 32'd13) begin fails++; $display("FAIL wd_stall got %0d want 13", stall_count); end
    endtask

    task automatic test_halt();
        idle_inputs();
        exmem_halt = 1'b1;
        #1;
        tests++; if (ctl !== C_ALL) begin fails++; $display("FAIL halt_issue got %b want %b", ctl, C_ALL); end
        tick();
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++; if (ctl !== C_DRAIN) begin fails++; $display("FAIL drain[%0d] got %b want %b", i, ctl, C_DRAIN); end
            tests++; if (halt !== 1'b0) begin fails++; $display("FAIL drain_halt[%0d] got %b want 0", i, halt); end
            tick();
        end
        exmem_xfer = 1'b1; exmem_memread = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tests++; if (ctl !== C_FREEZE || halt !== 1'b1) begin
                fails++; $display("FAIL halted[%0d] got ctl=%b halt=%b want ctl=%b halt=1", i, ctl, halt, C_FREEZE);
            end
            tick();
        end
        tests++; if (stall_count !== 32'd13) begin fails++; $display("FAIL halt_stall got %0d want 13", stall_count); end
    endtask

    task automatic test_reset_mid_dwait();
        nRST = 1'b0;
        #1;
        tests++; if (halt !== 1'b0 || mem_timeout !== 1'b0 || stall_count !== 32'd0) begin
            fails++; $display("FAIL rst_from_halt got halt=%b to=%b stall=%0d want 0 0 0", halt, mem_timeout, stall_count);
        end
        tick();
        nRST = 1'b1;
        idle_inputs();
        tick();
        exmem_memread = 1'b1;
        tick();
        tick();
        nRST = 1'b0;
        #1;
        tests++; if (ctl !== C_FREEZE) begin fails++; $display("FAIL rst_dwait_ctl got %b want %b", ctl, C_FREEZE); end
        tests++; if (stall_count !== 32'd0) begin fails++; $display("FAIL rst_dwait_stall got %0d want 0", stall_count); end
        tick();
        idle_inputs();
        nRST = 1'b1;
        #1;
        tests++; if (ctl !== C_ALL) begin fails++; $display("FAIL rst_dwait_release got %b want %b", ctl, C_ALL); end
        tick();
    endtask

    initial begin
        test_reset();
        test_dcache_wait();
        test_load_use();
        test_xfer();
        test_watchdog();
        test_halt();
        test_reset_mid_dwait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Central sequencer for the 5-stage pipeline latches: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Generates per-latch enable and flush, PC enable and the final CPU halt.
- Resolves, in priority order, data-cache wait, taken control transfer in MEM, load-use hazard and instruction-cache miss.
- Sequences halt drain and keeps stall and watchdog counters.

Parameters:
- DRAIN_CYCLES, 2: cycles MEM/WB keeps advancing after halt leaves EX/MEM, before HALTED.
- DWAIT_MAX, 255: DWAIT cycles after which mem_timeout sets.
- CNT_W, 32: stall_count width.

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- ihit  input  1  icache returns instruction this cycle.
- dhit  input  1  dcache completes MEM-stage access this cycle.
- exmem_memread  input  1  EX/MEM out_MemRead.
- exmem_memwrite  input  1  EX/MEM out_MemWrite.
- exmem_xfer  input  1  taken branch, jump, jr or jal resolved in MEM.
- exmem_halt  input  1  EX/MEM out_halt.
- idex_memread  input  1  load in EX.
- idex_wsel  input  5  EX destination register.
- ifid_rs  input  5  ID rs field.
- ifid_rt  input  5  ID rt field.
- pc_en  output  1  PC update.
- ifid_en, ifid_flush  output  1 each.
- idex_en, idex_flush  output  1 each.
- exmem_en, exmem_flush  output  1 each.
- memwb_en, memwb_flush  output  1 each.
- halt  output  1  CPU halted, sticky.
- mem_timeout  output  1  sticky watchdog flag.
- stall_count  output  CNT_W  cycles with pc_en=0 in RUN/DWAIT.

Behaviour:
- Reset (async, nRST=0): state=RUN; drain counter, dwait counter and stall_count = 0; halt=0; mem_timeout=0.
- Reset during any state, including DWAIT, DRAIN or HALTED, returns to the above immediately.
- Outputs are combinational from state and inputs, so all enables and flushes read 0 while nRST=0.
- Flush takes precedence over enable inside a latch.
- memop = exmem_memread | exmem_memwrite.
- lu = idex_memread & (idex_wsel != 0) & (idex_wsel == ifid_rs | idex_wsel == ifid_rt).
- RUN and DWAIT cycle outputs, first matching rule wins:
  1. memop & !dhit: all en=0, all flush=0, pc_en=0 (full freeze).
  2. exmem_xfer: pc_en=1; ifid_flush=1, idex_flush=1, exmem_flush=1; memwb_en=1. The transfer instruction moves to WB. The target is fetched next cycle regardless of ihit (PC must capture the target).
  3. lu: pc_en=0; ifid_en=0 (hold); idex_flush=1; exmem_en=1, memwb_en=1.
  4. !ihit: pc_en=0; ifid_flush=1 (bubble); idex_en=1, exmem_en=1, memwb_en=1.
  5. otherwise: all en=1, pc_en=1.
- FSM:
  - RUN -> DWAIT when rule 1 fires.
  - DWAIT -> RUN on dhit; that cycle applies rules 2-5.
  - RUN or DWAIT -> DRAIN when exmem_halt=1 and MEM/WB advances that cycle. Load drain counter = DRAIN_CYCLES-1.
  - DRAIN: pc_en=0; ifid_flush, idex_flush, exmem_flush=1; memwb_en=1. Counter decrements each cycle; at 0 -> HALTED.
  - HALTED: all en=0, flush=0; halt=1; terminal until reset.
- Simultaneous events:
  - exmem_halt with memop & !dhit: freeze has priority; DRAIN starts only once the halt instruction advances.
  - exmem_xfer with lu or !ihit: xfer wins.
- Watchdog:
  - dwait counter clears on RUN entry and increments each DWAIT cycle, saturating.
  - mem_timeout sets when the counter reaches DWAIT_MAX and stays set until reset. It has no effect on sequencing.
- stall_count increments, saturating at all-ones, on every RUN/DWAIT cycle with pc_en=0. It is frozen in DRAIN/HALTED.

Decomposition:
- cpu_types_pkg gains:
  - pipe_state_t enum {RUN, DWAIT, DRAIN, HALTED};
  - typedef latch_ctrl_t {en, flush};
  - regbits_t for 5-bit register selects.
- Sub-module hazard_detect: purely combinational lu computation.
- The FSM, counters and priority mux live in the top module.

Test Plan:
- Reset: nRST=0 mid-DWAIT -> state RUN; pc_en=0, all en/flush=0 while nRST=0; halt=0, stall_count=0; after release with ihit=1, all en=1.
- Dcache wait: memread=1, dhit=0 for 3 cycles then 1 -> 3 frozen cycles (all en=0), stall_count=3; dhit cycle has all en=1.
- Load-use: idex_memread=1, idex_wsel=8, ifid_rt=8, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1 for one cycle. Repeat with wsel=0 -> no stall.
- Taken branch + imiss: exmem_xfer=1, ihit=0, lu=1 -> pc_en=1, ifid/idex/exmem_flush=1, memwb_en=1.
- Halt with DRAIN_CYCLES=2: exmem_halt=1, ihit=1 -> 2 DRAIN cycles (memwb_en=1), then halt=1 held with all en=0 for 10+ cycles.
- Watchdog with DWAIT_MAX=4: memwrite=1, dhit=0 for 6 cycles -> mem_timeout rises once the dwait counter reaches 4 and stays 1 after dhit returns.
